display_demux: RTL

DISPLAY_DEMUX -- requirements
Module: display_demux

---
 rtl/display_demux.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/display_demux.sv
// Recovers complete 4-digit frames from a time-multiplexed active-low anode/hex display bus.
// Define DISPLAY_DEMUX_SYNC_EN to put a two-flop synchronizer on the inputs instead of a single register.
module display_demux #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] an_i,
    input  logic [3:0] hex_i,
    input  logic       clear_i,
    output logic [3:0] digit0_o,
    output logic [3:0] digit1_o,
    output logic [3:0] digit2_o,
    output logic [3:0] digit3_o,
    output logic       frame_valid_o,
    output logic [7:0] frame_cnt_o,
    output logic       seq_err_o,
    output logic       illegal_err_o
);

    localparam logic [7:0] STABLE_L   = 8'(STABLE_CYCLES);
    localparam logic [7:0] SAMPLE_RST = 8'hF0;

    typedef enum logic [1:0] {
        WAIT0,
        EXP1,
        EXP2,
        EXP3
    } state_t;

    typedef enum logic [2:0] {
        K_BLANK,
        K_D0,
        K_D1,
        K_D2,
        K_D3,
        K_ILLEGAL
    } kind_t;

    logic [7:0] sample;

`ifdef DISPLAY_DEMUX_SYNC_EN
    logic [7:0] sync_q1;
    logic [7:0] sync_q2;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q1 <= SAMPLE_RST;
            sync_q2 <= SAMPLE_RST;
        end else begin
            sync_q1 <= {an_i, hex_i};
            sync_q2 <= sync_q1;
        end
    end

    assign sample = sync_q2;
`else
    logic [7:0] sample_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sample_q <= SAMPLE_RST;
        end else begin
            sample_q <= {an_i, hex_i};
        end
    end

    assign sample = sample_q;
`endif

    // Stability tracking: run counter restarts on any change of the sampled bus.
    logic [7:0] prev_q;
    logic [7:0] run_cnt_q;
    logic [7:0] run_cnt_d;
    logic       capture;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        run_cnt_d = run_cnt_q;
        if (sample != prev_q) begin
            run_cnt_d = 8'd1;
        end else if (run_cnt_q != STABLE_L) begin
            run_cnt_d = run_cnt_q + 8'd1;
        end
    end

    // Fires only on the transition into saturation, so once per stable run.
    assign capture = (run_cnt_d == STABLE_L) && (run_cnt_q != STABLE_L);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q    <= SAMPLE_RST;
            run_cnt_q <= 8'd0;
        end else begin
            prev_q    <= sample;
            run_cnt_q <= run_cnt_d;
        end
    end

    kind_t kind;

    always_comb begin
        kind = K_ILLEGAL;
        case (sample[7:4])
            4'b1110: kind = K_D0;
            4'b1101: kind = K_D1;
            4'b1011: kind = K_D2;
            4'b0111: kind = K_D3;
            4'b1111: kind = K_BLANK;
            default: kind = K_ILLEGAL;
        endcase
    end

    state_t     state_q;
    state_t     state_d;
    logic [2:0] load_shadow;
    logic       commit;
    logic       seq_set;
    logic       illegal_set;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= WAIT0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        load_shadow = 3'b000;
        commit      = 1'b0;
        seq_set     = 1'b0;
        illegal_set = 1'b0;
        if (capture) begin
            case (kind)
                K_D0: begin
                    load_shadow[0] = 1'b1;
                    state_d        = EXP1;
                end
                K_D1: begin
                    if (state_q == EXP1) begin
                        load_shadow[1] = 1'b1;
                        state_d        = EXP2;
                    end else begin
                        seq_set = 1'b1;
                        state_d = WAIT0;
                    end
                end
                K_D2: begin
                    if (state_q == EXP2) begin
                        load_shadow[2] = 1'b1;
                        state_d        = EXP3;
                    end else begin
                        seq_set = 1'b1;
                        state_d = WAIT0;
                    end
                end
                K_D3: begin
                    if (state_q == EXP3) begin
                        commit  = 1'b1;
                    end else begin
                        seq_set = 1'b1;
                    end
                    state_d = WAIT0;
                end
                K_ILLEGAL: begin
                    illegal_set = 1'b1;
                    state_d     = WAIT0;
                end
                default: ;
            endcase
        end
    end

    // Shadows hold the partial frame; digit 3 bypasses them and goes straight to the output.
    logic [3:0] shadow_q [3];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: this tiny register array is reset explicitly because a mid-frame reset must discard it.
            for (int i = 0; i < 3; i++) begin
                shadow_q[i] <= 4'h0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (load_shadow[i]) begin
                    shadow_q[i] <= sample[3:0];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            digit0_o      <= 4'h0;
            digit1_o      <= 4'h0;
            digit2_o      <= 4'h0;
            digit3_o      <= 4'h0;
            frame_valid_o <= 1'b0;
            frame_cnt_o   <= 8'd0;
        end else begin
            frame_valid_o <= commit;
            if (commit) begin
                digit0_o    <= shadow_q[0];
                digit1_o    <= shadow_q[1];
                digit2_o    <= shadow_q[2];
                digit3_o    <= sample[3:0];
                frame_cnt_o <= frame_cnt_o + 8'd1;
            end
        end
    end

    // A new error event takes priority over a coincident clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            seq_err_o     <= 1'b0;
            illegal_err_o <= 1'b0;
        end else begin
            if (seq_set) begin
                seq_err_o <= 1'b1;
            end else if (clear_i) begin
                seq_err_o <= 1'b0;
            end
            if (illegal_set) begin
                illegal_err_o <= 1'b1;
            end else if (clear_i) begin
                illegal_err_o <= 1'b0;
            end
        end
    end

endmodule
